runtime_cfg_ctrl: RTL and testbench
===================================

Name: runtime_cfg_ctrl

Overview:
- Runtime companion to the static CVA6 build configuration. It holds NrFields run-time-tunable configuration fields, for example BHT/BTB enable, dual-issue enable, cache-way masks or WID override.
- Software or debug writes go to a shadow copy. A commit handshake drains the pipeline, then atomically copies shadow to active.
- Sits beside the CSR file. The active outputs fan out to frontend, issue and cache subsystems.

Parameters:
- NrFields, 8, number of configuration fields (1..32).
- FieldWidth, 8, bits per field (1..32).
- RstVals, all-zero, packed NrFields*FieldWidth reset value for both active and shadow copies.
- RoMask, all-zero, NrFields-bit mask; a 1 marks a read-only field, whose writes are ignored.
- TimeoutCycles, 1024, maximum drain wait before a commit aborts (>=2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- wr_valid_i  in  1  shadow write request
- wr_ready_o  out  1  shadow write accepted
- wr_idx_i  in  IdxW=max(1,$clog2(NrFields))  field index
- wr_data_i  in  FieldWidth  write data
- rd_idx_i  in  IdxW  shadow read index
- rd_data_o  out  FieldWidth  shadow field at rd_idx_i (combinational)
- commit_valid_i  in  1  commit request
- commit_ready_o  out  1  commit accepted
- flush_req_o  out  1  pipeline drain request
- pipeline_idle_i  in  1  pipeline drained, no outstanding memory ops
- cfg_o  out  NrFields*FieldWidth  active configuration
- cfg_update_o  out  1  one-cycle pulse when cfg_o changes
- commit_done_o  out  1  one-cycle pulse, commit finished successfully
- commit_err_o  out  1  one-cycle pulse, commit aborted on timeout
- pending_o  out  1  shadow differs from active (dirty)

Behaviour:
- Reset (async, rst_i=1):
  - active and shadow load RstVals; state IDLE; dirty=0; timeout counter=0.
  - cfg_o=RstVals; flush_req_o, cfg_update_o, commit_done_o, commit_err_o and pending_o are 0.
  - wr_ready_o=1 and commit_ready_o=1.
- States: IDLE, DRAIN, APPLY, ABORT.
- wr_ready_o and commit_ready_o are 1 only in IDLE.
- Writes:
  - Accepted on wr_valid_i&wr_ready_o; shadow[wr_idx_i] updates next edge.
  - Index >= NrFields, or RoMask[idx]=1: accepted but dropped, no state change.
  - dirty is set when the written value differs from active[idx].
  - rd_data_o returns 0 for an out-of-range index.
- Commit in IDLE, on commit_valid_i:
  - A same-cycle write is applied first and is included in the commit. The dirty evaluation uses the post-write shadow.
  - Not dirty: stay IDLE; commit_done_o pulses on the next cycle; no flush, no cfg_update_o.
  - Dirty: go to DRAIN; counter=0.
- DRAIN:
  - flush_req_o=1 (registered, asserted from the first DRAIN cycle).
  - Counter increments every cycle.
  - pipeline_idle_i=1 goes to APPLY. Idle takes priority over timeout if both occur in the same cycle.
  - Counter == TimeoutCycles-1 with idle still 0 goes to ABORT.
- APPLY, one cycle:
  - active<=shadow; dirty<=0; flush_req_o stays 1.
  - cfg_update_o and commit_done_o pulse in the cycle after APPLY, the same cycle cfg_o shows the new values.
  - Then IDLE.
- ABORT, one cycle:
  - shadow<=active (pending edits discarded); dirty<=0; flush_req_o=0.
  - commit_err_o pulses in the following cycle; cfg_o unchanged. Then IDLE.
- Latency: a dirty commit with pipeline_idle_i already high gives cfg_o updated 3 cycles after acceptance (DRAIN, APPLY, visible).
- cfg_o is driven only from the active registers; it never glitches or shows partial updates.
- pending_o equals dirty.
- Counter width: $clog2(TimeoutCycles)+1 bits; it never wraps within DRAIN.
- Reset mid-DRAIN or mid-APPLY: immediate return to reset values, including deassertion of flush_req_o.
- Commit requests outside IDLE are not accepted (commit_ready_o=0); the requester holds commit_valid_i.

Test Plan:
- Reset → cfg_o=RstVals, pending_o=0, wr_ready_o=1, all pulses 0. Write field 2=0x5A, read back → rd_data_o=0x5A, pending_o=1, cfg_o unchanged.
- Commit with pipeline_idle_i=1 → flush_req_o for 2 cycles; cfg_o field 2=0x5A and cfg_update_o=commit_done_o=1 three cycles after acceptance; pending_o=0.
- Commit with idle held 0, TimeoutCycles=16 → flush_req_o high 16 DRAIN cycles, then commit_err_o pulse; shadow field 2 restored to active value; cfg_o unchanged.
- Write to RoMask field and to idx=NrFields → accepted, no shadow change, pending_o stays 0. Commit → commit_done_o next cycle, no flush_req_o, no cfg_update_o.
- Same-cycle write (field 0=0x11) plus commit, idle asserted on the 4th DRAIN cycle → APPLY; cfg_o field 0=0x11. Writes attempted during DRAIN see wr_ready_o=0.
- Assert rst_i during DRAIN → flush_req_o drops asynchronously; cfg_o=RstVals and shadow=RstVals after release.

Source files
------------

// File: rtl/runtime_cfg_ctrl_if.sv
// Bus bundle for runtime_cfg_ctrl: shadow write/read port, commit handshake,
// pipeline-drain handshake and the active configuration with its status pulses.
interface runtime_cfg_ctrl_if #(
    parameter int unsigned NrFields   = 8,
    parameter int unsigned FieldWidth = 8
) ();
    localparam int unsigned IdxW = (NrFields > 1) ? $clog2(NrFields) : 1;

    logic                           wr_valid_i;
    logic                           wr_ready_o;
    logic [IdxW-1:0]                wr_idx_i;
    logic [FieldWidth-1:0]          wr_data_i;
    logic [IdxW-1:0]                rd_idx_i;
    logic [FieldWidth-1:0]          rd_data_o;
    logic                           commit_valid_i;
    logic                           commit_ready_o;
    logic                           flush_req_o;
    logic                           pipeline_idle_i;
    logic [NrFields*FieldWidth-1:0] cfg_o;
    logic                           cfg_update_o;
    logic                           commit_done_o;
    logic                           commit_err_o;
    logic                           pending_o;

    modport slave (
        input  wr_valid_i, wr_idx_i, wr_data_i, rd_idx_i,
        input  commit_valid_i, pipeline_idle_i,
        output wr_ready_o, rd_data_o, commit_ready_o, flush_req_o,
        output cfg_o, cfg_update_o, commit_done_o, commit_err_o, pending_o
    );

    modport master (
        output wr_valid_i, wr_idx_i, wr_data_i, rd_idx_i,
        output commit_valid_i, pipeline_idle_i,
        input  wr_ready_o, rd_data_o, commit_ready_o, flush_req_o,
        input  cfg_o, cfg_update_o, commit_done_o, commit_err_o, pending_o
    );
endinterface

// File: rtl/runtime_cfg_ctrl.sv
// Run-time configuration register bank: edits land in a shadow copy and are
// atomically committed to the active copy once the pipeline has drained.
module runtime_cfg_ctrl #(
    parameter int unsigned                      NrFields      = 8,
    parameter int unsigned                      FieldWidth    = 8,
    parameter logic [NrFields*FieldWidth-1:0]   RstVals       = '0,
    parameter logic [NrFields-1:0]              RoMask        = '0,
    parameter int unsigned                      TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    runtime_cfg_ctrl_if.slave    bus
);
    localparam int unsigned     IdxW     = (NrFields > 1) ? $clog2(NrFields) : 1;
    localparam int unsigned     IdxW1    = IdxW + 1;
    localparam int unsigned     CntW     = $clog2(TimeoutCycles) + 1;
    localparam logic [IdxW:0]   FieldCnt = IdxW1'(NrFields);
    localparam logic [CntW-1:0] CntLast  = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY,
        ST_ABORT
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [FieldWidth-1:0] r_active [NrFields];
    logic [FieldWidth-1:0] r_shadow [NrFields];
    logic                  r_dirty;
    logic                  r_flush;
    logic                  r_update;
    logic                  r_done;
    logic                  r_err;
    logic [CntW-1:0]       r_cnt;

    logic                  w_idle;
    logic                  w_wr_in_range;
    logic [IdxW-1:0]       w_wr_sel;
    logic                  w_wr_en;
    logic                  w_wr_diff;
    logic                  w_dirty_post;
    logic                  w_commit_fire;
    logic                  w_rd_in_range;
    logic [IdxW-1:0]       w_rd_sel;

    assign w_idle        = (r_state == ST_IDLE);
    // Out-of-range indices are clamped to 0 so the arrays are never indexed past their end.
    assign w_wr_in_range = ({1'b0, bus.wr_idx_i} < FieldCnt);
    assign w_wr_sel      = w_wr_in_range ? bus.wr_idx_i : '0;
    assign w_wr_en       = bus.wr_valid_i & w_idle & w_wr_in_range & ~RoMask[w_wr_sel];
    assign w_wr_diff     = w_wr_en & (bus.wr_data_i != r_active[w_wr_sel]);
    assign w_dirty_post  = r_dirty | w_wr_diff;
    assign w_commit_fire = bus.commit_valid_i & w_idle;

    assign w_rd_in_range = ({1'b0, bus.rd_idx_i} < FieldCnt);
    assign w_rd_sel      = w_rd_in_range ? bus.rd_idx_i : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Idle is tested before the timeout so a drain finishing on the last cycle still commits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_commit_fire && w_dirty_post) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.pipeline_idle_i) begin
                    w_state_next = ST_APPLY;
                end else if (r_cnt == CntLast) begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_APPLY: w_state_next = ST_IDLE;
            ST_ABORT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrFields; i++) begin
                r_active[i] <= RstVals[i*FieldWidth +: FieldWidth];
                r_shadow[i] <= RstVals[i*FieldWidth +: FieldWidth];
            end
            r_dirty  <= 1'b0;
            r_cnt    <= '0;
            r_flush  <= 1'b0;
            r_update <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_update <= (r_state == ST_APPLY);
            r_done   <= (r_state == ST_APPLY) | (w_commit_fire & ~w_dirty_post);
            r_err    <= (r_state == ST_ABORT);
            r_flush  <= (w_state_next == ST_DRAIN) | (w_state_next == ST_APPLY);
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_wr_en) begin
                        r_shadow[w_wr_sel] <= bus.wr_data_i;
                    end
                    if (w_wr_diff) begin
                        r_dirty <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_APPLY: begin
                    for (int unsigned i = 0; i < NrFields; i++) begin
                        r_active[i] <= r_shadow[i];
                    end
                    r_dirty <= 1'b0;
                end
                ST_ABORT: begin
                    for (int unsigned i = 0; i < NrFields; i++) begin
                        r_shadow[i] <= r_active[i];
                    end
                    r_dirty <= 1'b0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NrFields; gi++) begin : g_cfg_out
            assign bus.cfg_o[gi*FieldWidth +: FieldWidth] = r_active[gi];
        end
    endgenerate

    assign bus.rd_data_o      = w_rd_in_range ? r_shadow[w_rd_sel] : '0;
    assign bus.wr_ready_o     = w_idle;
    assign bus.commit_ready_o = w_idle;
    assign bus.flush_req_o    = r_flush;
    assign bus.cfg_update_o   = r_update;
    assign bus.commit_done_o  = r_done;
    assign bus.commit_err_o   = r_err;
    assign bus.pending_o      = r_dirty;

endmodule

// File: tb/tb_runtime_cfg_ctrl.sv
// Scoreboard bench for runtime_cfg_ctrl: stimulus queues the expected commit outcome,
// a negedge monitor pops and checks it whenever a done/err/update pulse appears.
module tb_runtime_cfg_ctrl;
    localparam int unsigned NF  = 6;
    localparam int unsigned FW  = 8;
    localparam int unsigned TO  = 16;
    localparam logic [47:0] RST = 48'h15_14_13_12_11_10;
    localparam logic [5:0]  RO  = 6'b001000;
    localparam logic [47:0] CFG_A = 48'h15_14_13_5A_11_10;
    localparam logic [47:0] CFG_B = 48'h15_14_13_5A_11_11;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   mon_flush = 0;

    typedef struct {
        logic [2:0]  pulses;
        logic [47:0] cfg;
        int          flush;
        int          lat;
        int          stamp;
    } exp_t;
    exp_t sb[$];

    runtime_cfg_ctrl_if #(.NrFields(NF), .FieldWidth(FW)) cfg_bus ();

    runtime_cfg_ctrl #(
        .NrFields(NF), .FieldWidth(FW), .RstVals(RST), .RoMask(RO), .TimeoutCycles(TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (cfg_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] idx, input logic [7:0] data);
        cfg_bus.wr_valid_i = 1'b1;
        cfg_bus.wr_idx_i   = idx;
        cfg_bus.wr_data_i  = data;
        @(negedge clk);
        chk("wr_ready", 64'(cfg_bus.wr_ready_o), 64'd1);
        tick();
        cfg_bus.wr_valid_i = 1'b0;
    endtask

    task automatic commit(input logic [47:0] cfg, input logic [2:0] p, input int fl,
                          input int lat, input bit with_wr, input logic [2:0] idx,
                          input logic [7:0] data);
        exp_t e;
        cfg_bus.commit_valid_i = 1'b1;
        if (with_wr) begin
            cfg_bus.wr_valid_i = 1'b1;
            cfg_bus.wr_idx_i   = idx;
            cfg_bus.wr_data_i  = data;
        end
        @(negedge clk);
        chk("commit_ready", 64'(cfg_bus.commit_ready_o), 64'd1);
        e.pulses = p;
        e.cfg    = cfg;
        e.flush  = fl;
        e.lat    = lat;
        e.stamp  = cyc;
        sb.push_back(e);
        tick();
        cfg_bus.commit_valid_i = 1'b0;
        cfg_bus.wr_valid_i     = 1'b0;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("sb_drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_rd(input string name, input logic [2:0] idx, input logic [7:0] exp);
        cfg_bus.rd_idx_i = idx;
        #1;
        chk(name, 64'(cfg_bus.rd_data_o), 64'(exp));
    endtask

    // Monitor: one comparison set per status pulse, independent of the stimulus thread.
    initial begin
        exp_t e;
        logic [2:0] p;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_flush = 0;
            end else begin
                if (cfg_bus.flush_req_o) mon_flush++;
                p = {cfg_bus.cfg_update_o, cfg_bus.commit_done_o, cfg_bus.commit_err_o};
                if (p != 3'b000) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", 64'(p), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("pulses", 64'(p), 64'(e.pulses));
                        chk("cfg_at_pulse", 64'(cfg_bus.cfg_o), 64'(e.cfg));
                        chk("flush_cycles", 64'(mon_flush), 64'(e.flush));
                        chk("latency", 64'(cyc - e.stamp), 64'(e.lat));
                        $display("txn: pulses=%b cfg=%h flush=%0d lat=%0d", p, cfg_bus.cfg_o,
                                 mon_flush, cyc - e.stamp);
                    end
                    mon_flush = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_bus.wr_valid_i      = 1'b0;
        cfg_bus.wr_idx_i        = '0;
        cfg_bus.wr_data_i       = '0;
        cfg_bus.rd_idx_i        = '0;
        cfg_bus.commit_valid_i  = 1'b0;
        cfg_bus.pipeline_idle_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cfg", 64'(cfg_bus.cfg_o), 64'(RST));
        chk("rst_pending", 64'(cfg_bus.pending_o), 64'd0);
        chk("rst_readies", 64'({cfg_bus.wr_ready_o, cfg_bus.commit_ready_o}), 64'd3);
        chk("rst_pulses", 64'({cfg_bus.flush_req_o, cfg_bus.cfg_update_o,
                               cfg_bus.commit_done_o, cfg_bus.commit_err_o}), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Shadow write and readback; active copy untouched.
        write(3'd2, 8'h5A);
        chk_rd("rd_f2", 3'd2, 8'h5A);
        chk_rd("rd_oob", 3'd7, 8'h00);
        chk("pending_after_wr", 64'(cfg_bus.pending_o), 64'd1);
        chk("cfg_unchanged", 64'(cfg_bus.cfg_o), 64'(RST));

        // Dirty commit with pipeline already idle.
        commit(CFG_A, 3'b110, 2, 3, 1'b0, 3'd0, 8'h00);
        wait_sb();
        chk("pending_after_commit", 64'(cfg_bus.pending_o), 64'd0);

        // Timeout abort.
        write(3'd2, 8'h77);
        cfg_bus.pipeline_idle_i = 1'b0;
        commit(CFG_A, 3'b001, 16, 18, 1'b0, 3'd0, 8'h00);
        wait_sb();
        cfg_bus.pipeline_idle_i = 1'b1;
        chk_rd("rd_f2_restored", 3'd2, 8'h5A);
        chk("pending_after_abort", 64'(cfg_bus.pending_o), 64'd0);

        // Read-only field and out-of-range index writes are dropped.
        write(3'd3, 8'hEE);
        write(3'd6, 8'hEE);
        chk_rd("rd_ro_field", 3'd3, 8'h13);
        chk("pending_after_drop", 64'(cfg_bus.pending_o), 64'd0);
        commit(CFG_A, 3'b010, 0, 1, 1'b0, 3'd0, 8'h00);
        wait_sb();

        // Same-cycle write + commit, idle arrives on the 4th drain cycle.
        cfg_bus.pipeline_idle_i = 1'b0;
        commit(CFG_B, 3'b110, 5, 6, 1'b1, 3'd0, 8'h11);
        cfg_bus.wr_valid_i = 1'b1;
        cfg_bus.wr_idx_i   = 3'd4;
        cfg_bus.wr_data_i  = 8'h99;
        @(negedge clk);
        chk("wr_ready_in_drain", 64'(cfg_bus.wr_ready_o), 64'd0);
        chk("commit_ready_in_drain", 64'(cfg_bus.commit_ready_o), 64'd0);
        tick();
        tick();
        tick();
        cfg_bus.pipeline_idle_i = 1'b1;
        cfg_bus.wr_valid_i      = 1'b0;
        wait_sb();
        chk_rd("rd_f0_committed", 3'd0, 8'h11);
        chk_rd("rd_f4_blocked", 3'd4, 8'h14);
        chk("pending_after_b", 64'(cfg_bus.pending_o), 64'd0);

        // Reset in the middle of a drain.
        write(3'd5, 8'h42);
        cfg_bus.pipeline_idle_i = 1'b0;
        cfg_bus.commit_valid_i  = 1'b1;
        @(negedge clk);
        chk("commit_ready_pre_rst", 64'(cfg_bus.commit_ready_o), 64'd1);
        tick();
        cfg_bus.commit_valid_i = 1'b0;
        tick();
        @(negedge clk);
        chk("flush_in_drain", 64'(cfg_bus.flush_req_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("flush_async_drop", 64'(cfg_bus.flush_req_o), 64'd0);
        tick();
        rst = 1'b0;
        cfg_bus.pipeline_idle_i = 1'b1;
        @(negedge clk);
        chk("cfg_after_rst", 64'(cfg_bus.cfg_o), 64'(RST));
        chk("pending_after_rst", 64'(cfg_bus.pending_o), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk_rd("rd_after_rst", 3'(i), RST[i*8 +: 8]);
        end
        tick();
        tick();

        chk("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
